// File: rtl/calc_result_bcd.sv
// calc_result_bcd: sequential binary-to-BCD converter (double dabble, one bit
// per clock) for the mini-calculator result, with held display-ready outputs.
// Optional remainder conversion path is built when CALC_BCD_REM_EN is defined.
module calc_result_bcd #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      result,
    input  logic [7:0]            remainder,
    input  logic                  error,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [11:0]           rem_bcd,
    output logic                  err_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned REM_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BCD_W+WIDTH-1:0] cat;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef CALC_BCD_REM_EN
    logic [REM_W-1:0]   rshift_q, rshift_d;
    logic [11:0]        rscratch_q, rscratch_d;
    logic [11:0]        rem_bcd_q, rem_bcd_d;
    logic [REM_W+11:0]  rcat;

    // Three-digit variant of add3 for the remainder path.
    function automatic logic [11:0] add3_rem(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction
`endif

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CALC_BCD_REM_EN
            rshift_q   <= '0;
            rscratch_q <= '0;
            rem_bcd_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef CALC_BCD_REM_EN
            rshift_q   <= rshift_d;
            rscratch_q <= rscratch_d;
            rem_bcd_q  <= rem_bcd_d;
`endif
        end
    end

    // Next-state, shift-add-3 datapath and output load logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cat       = {add3(scratch_q), shift_q} << 1;
`ifdef CALC_BCD_REM_EN
        rshift_d   = rshift_q;
        rscratch_d = rscratch_q;
        rem_bcd_d  = rem_bcd_q;
        rcat       = {add3_rem(rscratch_q), rshift_q} << 1;
`endif
        case (state_q)
            IDLE: begin
                if (start && error) begin
                    state_d = ERR;
                    busy_d  = 1'b1;
                end else if (start) begin
                    state_d   = SHIFT;
                    busy_d    = 1'b1;
                    shift_d   = result;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
`ifdef CALC_BCD_REM_EN
                    rshift_d   = remainder;
                    rscratch_d = '0;
`endif
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = cat;
                cnt_d = cnt_q - CNT_W'(1);
`ifdef CALC_BCD_REM_EN
                // Remainder needs only 8 shifts; it runs during the first 8 cycles.
                if (cnt_q > CNT_W'(WIDTH - REM_W)) {rscratch_d, rshift_d} = rcat;
`endif
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    bcd_d   = cat[BCD_W+WIDTH-1 -: BCD_W];
`ifdef CALC_BCD_REM_EN
                    rem_bcd_d = rscratch_d;
`endif
                end
            end
            ERR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b1;
                bcd_d   = '1;
`ifdef CALC_BCD_REM_EN
                rem_bcd_d = 12'hFFF;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd     = bcd_q;
    assign err_out = err_q;

`ifdef CALC_BCD_REM_EN
    assign rem_bcd = rem_bcd_q;
`else
    // Remainder path not built; the display sees blank-zero remainder digits.
    logic unused_remainder;
    assign unused_remainder = ^remainder;
    assign rem_bcd = 12'h000;
`endif

endmodule

// File: doc/calc_result_bcd.md
# calc_result_bcd

- Sequential binary-to-BCD converter directly downstream of the mini calculator.
- Captures the calculator's 16-bit `result`, its `error` flag and, optionally, the 8-bit `remainder` on a start strobe.
- Converts them to packed BCD using iterative shift-add-3 (double dabble), one bit per clock.
- Presents held, display-ready digits with a done pulse for the seven-segment / display stage that follows.

## Interface

Parameters:
- `WIDTH`, 16, binary input width; also the number of shift cycles per conversion.
- `DIGITS`, 5, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: conversion request; accepted only when `busy`=0.
- `result` input WIDTH: unsigned binary value from the calculator.
- `remainder` input 8: division remainder (used only with the macro).
- `error` input 1: calculator divide-by-zero flag.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when outputs update.
- `bcd` output 4*DIGITS: packed BCD of `result`, digit 0 in bits [3:0].
- `rem_bcd` output 12: packed BCD of `remainder` (macro-dependent).
- `err_out` output 1: latched error indicator for the display.

## Operation

- Reset values:
  - `busy`=0, `done`=0, `err_out`=0.
  - `bcd`=0, `rem_bcd`=0.
  - FSM in IDLE; internal shift and scratch registers cleared.
- State machine: IDLE, SHIFT, ERR.
  - IDLE, `start`=1, `error`=0: capture `result` (and `remainder`) into a shift register; clear the BCD scratch; bit counter = WIDTH; go to SHIFT.
  - IDLE, `start`=1, `error`=1: go to ERR; `result` is not sampled (it is undefined upstream).
  - SHIFT, each cycle:
    - Each scratch digit ≥ 5 gets +3.
    - The {scratch, shift} register shifts left one bit, MSB of the shift register entering scratch bit 0.
    - Counter decrements.
    - On the cycle the counter reaches 0: load `bcd` from scratch, pulse `done`, clear `err_out`, return to IDLE.
  - ERR, one cycle: `bcd` = all 4'hF (blank code), `rem_bcd` = 12'hFFF, `err_out`=1, pulse `done`, return to IDLE.
- Arithmetic:
  - `result` is treated as unsigned.
  - Upstream subtraction underflow wraps, e.g. 3−5 arrives as 16'hFFFE and displays 65534; no sign handling.
- Outputs hold their last loaded value until the next `done`; scratch contents are never visible on `bcd`.
- `start` while `busy`=1 is ignored: it is not queued and does not alter the capture.
- `result` / `error` changes after capture have no effect on the conversion in flight.
- Reset mid-conversion: next edge returns to IDLE with all outputs at reset values; no `done` is issued.
- `start` and `rst` high in the same cycle: reset wins.

## Timing

- `start` sampled high at edge k with `busy`=0:
  - Normal path: `busy`=1 after edge k; shifts occur on edges k+1 … k+WIDTH.
  - Normal path: `bcd` loaded, `done`=1 and `busy`=0 after edge k+WIDTH. Latency is WIDTH cycles (16 at default).
  - Error path: `busy`=1 after edge k; `done`=1 and `busy`=0 after edge k+1. Latency is 1 cycle.
- `done` is high for exactly one cycle.
- A new `start` may be accepted on the same edge that `done` is asserted, because `busy` is already 0 for that cycle's sampling.
- Back-to-back throughput: one conversion per WIDTH+1 cycles.

## Configuration

- Macro: `CALC_BCD_REM_EN`.
- Defined:
  - An 8-bit / 3-digit shift-add-3 path runs in parallel with the main path.
  - Its 8 shifts complete within the main WIDTH cycles; the result is held in scratch until the final cycle.
  - `rem_bcd` loads on the same edge as `bcd`. Latency is unchanged.
- Undefined:
  - Remainder logic is not built; `remainder` is unused.
  - `rem_bcd` is tied to 12'h000 permanently, including in the ERR state.

## Test plan

- Reset, then `result`=16'd65025 (255×255), `start` pulse → `busy` 16 cycles, then `done` one cycle with `bcd`=20'h65025, `err_out`=0.
- `result`=0 → `bcd`=20'h00000 after 16 cycles; `result`=16'hFFFF → `bcd`=20'h65535.
- `error`=1, `start` → `done` one cycle after start, `bcd`=20'hFFFFF, `err_out`=1; next valid conversion of 42 → `bcd`=20'h00042, `err_out`=0.
- Start 1234; change `result` to 999 and re-pulse `start` at cycle 5 → single `done` with `bcd`=20'h01234; no second `done`.
- Assert `rst` at cycle 8 of a conversion → no `done`; all outputs 0 next cycle; a fresh start of 7 yields 20'h00007.
- With `CALC_BCD_REM_EN`: `result`=3, `remainder`=200 → `bcd`=20'h00003, `rem_bcd`=12'h200. Without the macro → `rem_bcd`=12'h000.
